// File: rtl/dp_video_capture_if.sv
// Video stream plus framebuffer write port seen by the capture block.
// The slave side is the capture block: it consumes the stream and
// drives the framebuffer write port. The master side is the stream
// source / framebuffer owner.
`timescale 1ns/1ps
interface dp_video_capture_if;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [35:0] video;
  logic        fb_we;
  logic [15:0] fb_waddr;
  logic [23:0] fb_wdata;

  modport master (
    output de, hsync, vsync, video,
    input  fb_we, fb_waddr, fb_wdata
  );

  modport slave (
    input  de, hsync, vsync, video,
    output fb_we, fb_waddr, fb_wdata
  );
endinterface

// File: rtl/dp_video_capture.sv
// Receiver for the upscaled NES video stream. Measures active timing
// every frame, locks after one verified frame, and once locked
// decimates the 4x-upscaled window back to NES resolution, writing
// RGB888 samples into a framebuffer write port.
`timescale 1ns/1ps
module dp_video_capture #(
  parameter int H_ACTIVE     = 1920,
  parameter int V_ACTIVE     = 1080,
  parameter int X_OFF        = 448,
  parameter int Y_OFF        = 60,
  parameter int SAMPLE_PHASE = 1,
  // Size of the upscaled window in pixels (4x the NES frame).
  parameter int WIN_W        = 1024,
  parameter int WIN_H        = 960
) (
  input  logic                    clk_pixel,
  input  logic                    rst_pixel_n,
  dp_video_capture_if.slave       vid,
  output logic                    frame_done,
  output logic                    locked,
  output logic [11:0]             h_active_meas,
  output logic [11:0]             v_active_meas,
  output logic [7:0]              mismatch_count
);

  localparam logic [11:0] H_EXP   = 12'(H_ACTIVE);
  localparam logic [11:0] V_EXP   = 12'(V_ACTIVE);
  localparam logic [11:0] X_OFF12 = 12'(X_OFF);
  localparam logic [11:0] Y_OFF12 = 12'(Y_OFF);
  // Window bounds carried at 13 bits so OFF+WIN never wraps.
  localparam logic [12:0] X_LO    = 13'(X_OFF);
  localparam logic [12:0] X_HI    = 13'(X_OFF + WIN_W);
  localparam logic [12:0] Y_LO    = 13'(Y_OFF);
  localparam logic [12:0] Y_HI    = 13'(Y_OFF + WIN_H);
  localparam logic [1:0]  PHASE   = 2'(SAMPLE_PHASE);

  typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_t;

  state_t      state;
  logic        vsync_q;
  logic        de_q;
  logic [11:0] ax;
  logic [11:0] ay;
  logic        frame_err;

  logic        vs_rise;
  logic        de_fall;
  logic        good;
  logic [11:0] dx;
  logic [11:0] dy;
  logic        in_window;
  logic        capture;

  assign vs_rise   = vid.vsync & ~vsync_q;
  assign de_fall   = ~vid.de & de_q;
  assign good      = (ay == V_EXP) & ~frame_err & (h_active_meas == H_EXP);
  assign dx        = ax - X_OFF12;
  assign dy        = ay - Y_OFF12;
  assign in_window = ({1'b0, ax} >= X_LO) && ({1'b0, ax} < X_HI) &&
                     ({1'b0, ay} >= Y_LO) && ({1'b0, ay} < Y_HI);
  assign capture   = vid.de && in_window && (dx[1:0] == PHASE) && (dy[1:0] == PHASE);

  // hsync, the padding nibbles of video and the top window-offset bits
  // carry no information for this block.
  logic unused_bits;
  assign unused_bits = ^{vid.hsync, vid.video[27:24], vid.video[15:12],
                         vid.video[3:0], dx[11:10], dy[11:10]};

  // Edge detection registers for vsync and de.
  always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      vsync_q <= vid.vsync;
      de_q    <= vid.de;
    end
  end

  // Position counters and per-line / per-frame timing measurement.
  always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      ax            <= '0;
      ay            <= '0;
      frame_err     <= 1'b0;
      h_active_meas <= '0;
      v_active_meas <= '0;
    end else begin
      // Column counter saturates rather than wrapping on runaway lines.
      if (vid.de) begin
        if (ax != 12'hFFF) ax <= ax + 12'd1;
      end else if (de_fall) begin
        ax <= '0;
      end

      if (de_fall) h_active_meas <= ax;

      if (vs_rise) begin
        v_active_meas <= ay;
        ay            <= '0;
        // de still high across the frame boundary spoils the new frame.
        frame_err     <= vid.de;
      end else if (de_fall) begin
        if (ay != 12'hFFF) ay <= ay + 12'd1;
        if (ax != H_EXP) frame_err <= 1'b1;
      end
    end
  end

  // Lock state machine: judge each frame at the vsync edge that ends it.
  always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      state          <= SEEK;
      locked         <= 1'b0;
      frame_done     <= 1'b0;
      mismatch_count <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        SEEK: begin
          if (vs_rise) state <= MEASURE;
        end
        MEASURE: begin
          if (vs_rise && good) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (vs_rise) begin
            if (good) begin
              frame_done <= 1'b1;
            end else begin
              state  <= MEASURE;
              locked <= 1'b0;
              if (mismatch_count != 8'hFF) mismatch_count <= mismatch_count + 8'd1;
            end
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

  // Framebuffer write port: one sample per 4x4 block while locked.
  always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      vid.fb_we    <= 1'b0;
      vid.fb_waddr <= '0;
      vid.fb_wdata <= '0;
    end else begin
      vid.fb_we <= 1'b0;
      if (state == LOCKED && capture) begin
        vid.fb_we    <= 1'b1;
        vid.fb_waddr <= {dy[9:2], dx[9:2]};
        vid.fb_wdata <= {vid.video[35:28], vid.video[23:16], vid.video[11:4]};
      end
    end
  end

endmodule

// File: tb/tb_dp_video_capture.sv
// Directed bench for dp_video_capture using a scaled-down raster:
// 48x24 active, window 32x16 at offset (8,4), phase 1. That gives an
// 8x4 decimated frame: 32 writes, addresses 0x0000..0x0307.
`timescale 1ns/1ps
module tb_dp_video_capture;
  localparam int HA = 48;
  localparam int VA = 24;
  localparam int XO = 8;
  localparam int YO = 4;
  localparam int PH = 1;
  localparam int WW = 32;
  localparam int WH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dp_video_capture_if vif();
  logic        frame_done;
  logic        locked;
  logic [11:0] h_meas;
  logic [11:0] v_meas;
  logic [7:0]  mm;

  dp_video_capture #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .X_OFF(XO), .Y_OFF(YO),
    .SAMPLE_PHASE(PH), .WIN_W(WW), .WIN_H(WH)
  ) dut (
    .clk_pixel      (clk),
    .rst_pixel_n    (rst_n),
    .vid            (vif),
    .frame_done     (frame_done),
    .locked         (locked),
    .h_active_meas  (h_meas),
    .v_active_meas  (v_meas),
    .mismatch_count (mm)
  );

  int checks = 0;
  int errors = 0;

  // write monitor state
  int          wr_count, order_bad, data_bad, rst_bad, done_count;
  logic [15:0] first_addr, last_addr;
  logic [23:0] d203;
  bit          seen203;
  bit          pat_mode;
  logic [23:0] exp_d;
  int          mfx, mfy;

  // observations from stimulus tasks
  logic        locked_pre, locked_post, done_post, done_after;
  logic [7:0]  mm_post;
  logic [11:0] vmeas_post;
  logic        rst_fbwe_pre, rst_locked_after, rst_fbwe_after;
  logic [7:0]  rst_mm_after;
  logic [11:0] hm [0:63];

  always @(negedge clk) begin
    if (!rst_n && (vif.fb_we || locked || frame_done || mm != 0 || h_meas != 0 ||
                   v_meas != 0 || vif.fb_waddr != 0 || vif.fb_wdata != 0))
      rst_bad++;
    if (frame_done) done_count++;
    if (vif.fb_we) begin
      if (wr_count == 0) first_addr = vif.fb_waddr;
      else if (vif.fb_waddr <= last_addr) order_bad++;
      last_addr = vif.fb_waddr;
      wr_count++;
      if (vif.fb_waddr == 16'h0203) begin
        seen203 = 1'b1;
        d203 = vif.fb_wdata;
      end
      mfx = int'(vif.fb_waddr[7:0]);
      mfy = int'(vif.fb_waddr[15:8]);
      if (pat_mode) exp_d = {8'(XO + PH + 4 * mfx), 8'(YO + PH + 4 * mfy), 8'hA5};
      else          exp_d = 24'h545454;
      if (vif.fb_wdata !== exp_d) data_bad++;
    end
  end

  task automatic clear_mon;
    wr_count = 0; order_bad = 0; data_bad = 0; done_count = 0;
    seen203 = 1'b0; d203 = '0; first_addr = '0; last_addr = '0;
  endtask

  // One frame of active lines followed by short horizontal blanking.
  task automatic send_frame(input int nlines, input int short_idx, input int short_len,
                            input bit pat, input int rst_line);
    int len;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_idx) ? short_len : HA;
      for (int c = 0; c < len; c++) begin
        @(posedge clk); #1;
        vif.de = 1'b1;
        vif.hsync = 1'b0;
        vif.video = pat ? {8'(c), 4'h0, 8'(l), 4'h0, 8'hA5, 4'h0}
                        : {8'h54, 4'h0, 8'h54, 4'h0, 8'h54, 4'h0};
        if (l == rst_line && c == 10) begin
          rst_fbwe_pre = vif.fb_we;
          rst_n = 1'b0;
          #1;
          rst_locked_after = locked;
          rst_fbwe_after = vif.fb_we;
          rst_mm_after = mm;
        end
        if (l == rst_line && c == 14) rst_n = 1'b1;
      end
      for (int b = 0; b < 8; b++) begin
        @(posedge clk); #1;
        vif.de = 1'b0;
        vif.hsync = (b >= 2 && b < 5);
        vif.video = '0;
      end
      if (l < 64) hm[l] = h_meas;
    end
  endtask

  // Vertical sync pulse; samples state just before and after the edge.
  task automatic vs_pulse;
    @(posedge clk); #1; vif.vsync = 1'b1;
    @(negedge clk); locked_pre = locked;
    @(negedge clk);
    locked_post = locked; done_post = frame_done; mm_post = mm; vmeas_post = v_meas;
    @(negedge clk); done_after = frame_done;
    @(posedge clk); #1; vif.vsync = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset;
    clear_mon; rst_bad = 0; rst_n = 1'b0;
    send_frame(VA, -1, 0, 1'b0, -1);
    vs_pulse;
    checks++; if (wr_count !== 0) begin errors++; $display("FAIL reset_writes: got %0d expected 0", wr_count); end
    checks++; if (rst_bad !== 0) begin errors++; $display("FAIL reset_outputs: got %0d nonzero samples expected 0", rst_bad); end
    checks++; if (locked !== 1'b0 || mm !== 8'd0) begin errors++; $display("FAIL reset_state: got locked=%0b mm=%0d expected 0/0", locked, mm); end
    checks++; if (h_meas !== 12'd0 || v_meas !== 12'd0) begin errors++; $display("FAIL reset_meas: got h=%0d v=%0d expected 0/0", h_meas, v_meas); end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_lock_in;
    clear_mon; pat_mode = 1'b0;
    send_frame(VA, -1, 0, 1'b0, -1);
    vs_pulse;
    checks++; if (locked_post !== 1'b0) begin errors++; $display("FAIL lock_vs1: got locked=%0b expected 0", locked_post); end
    send_frame(VA, -1, 0, 1'b0, -1);
    vs_pulse;
    checks++; if (locked_pre !== 1'b0 || locked_post !== 1'b1) begin errors++; $display("FAIL lock_vs2: got pre=%0b post=%0b expected 0/1", locked_pre, locked_post); end
    checks++; if (done_post !== 1'b0) begin errors++; $display("FAIL lock_vs2_done: got %0b expected 0", done_post); end
    checks++; if (wr_count !== 0) begin errors++; $display("FAIL lock_prelock_writes: got %0d expected 0", wr_count); end
    clear_mon;
    send_frame(VA, -1, 0, 1'b0, -1);
    checks++; if (wr_count !== 32) begin errors++; $display("FAIL lock_write_count: got %0d expected 32", wr_count); end
    checks++; if (first_addr !== 16'h0000) begin errors++; $display("FAIL lock_first_addr: got %04h expected 0000", first_addr); end
    checks++; if (last_addr !== 16'h0307) begin errors++; $display("FAIL lock_last_addr: got %04h expected 0307", last_addr); end
    checks++; if (data_bad !== 0 || order_bad !== 0) begin errors++; $display("FAIL lock_data_order: got bad_data=%0d bad_order=%0d expected 0/0", data_bad, order_bad); end
    checks++; if (h_meas !== 12'd48) begin errors++; $display("FAIL lock_h_meas: got %0d expected 48", h_meas); end
    vs_pulse;
    checks++; if (done_post !== 1'b1 || done_after !== 1'b0) begin errors++; $display("FAIL lock_done_pulse: got %0b,%0b expected 1,0", done_post, done_after); end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL lock_done_count: got %0d expected 1", done_count); end
    checks++; if (vmeas_post !== 12'd24) begin errors++; $display("FAIL lock_v_meas: got %0d expected 24", vmeas_post); end
  endtask

  task automatic test_mapping;
    clear_mon; pat_mode = 1'b1;
    send_frame(VA, -1, 0, 1'b1, -1);
    checks++; if (wr_count !== 32) begin errors++; $display("FAIL map_write_count: got %0d expected 32", wr_count); end
    checks++; if (seen203 !== 1'b1 || d203 !== 24'h150DA5) begin errors++; $display("FAIL map_0203: got seen=%0b data=%06h expected 1/150da5", seen203, d203); end
    checks++; if (data_bad !== 0 || order_bad !== 0) begin errors++; $display("FAIL map_all: got bad_data=%0d bad_order=%0d expected 0/0", data_bad, order_bad); end
    vs_pulse;
    checks++; if (done_post !== 1'b1 || locked_post !== 1'b1) begin errors++; $display("FAIL map_vs: got done=%0b locked=%0b expected 1/1", done_post, locked_post); end
    pat_mode = 1'b0;
  endtask

  task automatic test_short_frame;
    clear_mon;
    send_frame(VA - 1, -1, 0, 1'b0, -1);
    checks++; if (wr_count !== 32) begin errors++; $display("FAIL short_frame_writes: got %0d expected 32", wr_count); end
    vs_pulse;
    checks++; if (vmeas_post !== 12'd23) begin errors++; $display("FAIL short_frame_vmeas: got %0d expected 23", vmeas_post); end
    checks++; if (locked_post !== 1'b0 || mm_post !== 8'd1 || done_post !== 1'b0) begin errors++; $display("FAIL short_frame_vs: got locked=%0b mm=%0d done=%0b expected 0/1/0", locked_post, mm_post, done_post); end
    clear_mon;
    send_frame(VA, -1, 0, 1'b0, -1);
    checks++; if (wr_count !== 0) begin errors++; $display("FAIL short_frame_next_writes: got %0d expected 0", wr_count); end
    vs_pulse;
    checks++; if (locked_post !== 1'b1 || done_post !== 1'b0) begin errors++; $display("FAIL short_frame_relock: got locked=%0b done=%0b expected 1/0", locked_post, done_post); end
    clear_mon;
    send_frame(VA, -1, 0, 1'b0, -1);
    checks++; if (wr_count !== 32) begin errors++; $display("FAIL short_frame_resume: got %0d expected 32", wr_count); end
    vs_pulse;
    checks++; if (done_post !== 1'b1) begin errors++; $display("FAIL short_frame_done: got %0b expected 1", done_post); end
  endtask

  task automatic test_short_line;
    clear_mon;
    send_frame(VA, 3, HA - 1, 1'b0, -1);
    checks++; if (hm[3] !== 12'd47) begin errors++; $display("FAIL short_line_meas: got %0d expected 47", hm[3]); end
    checks++; if (hm[4] !== 12'd48) begin errors++; $display("FAIL short_line_next_meas: got %0d expected 48", hm[4]); end
    vs_pulse;
    checks++; if (locked_post !== 1'b0 || mm_post !== 8'd2 || done_post !== 1'b0) begin errors++; $display("FAIL short_line_vs: got locked=%0b mm=%0d done=%0b expected 0/2/0", locked_post, mm_post, done_post); end
    send_frame(VA, -1, 0, 1'b0, -1);
    vs_pulse;
    checks++; if (locked_post !== 1'b1) begin errors++; $display("FAIL short_line_relock: got %0b expected 1", locked_post); end
  endtask

  task automatic test_async_reset;
    send_frame(VA, -1, 0, 1'b0, 13);
    checks++; if (rst_fbwe_pre !== 1'b1) begin errors++; $display("FAIL areset_pre_we: got %0b expected 1", rst_fbwe_pre); end
    checks++; if (rst_locked_after !== 1'b0 || rst_fbwe_after !== 1'b0) begin errors++; $display("FAIL areset_immediate: got locked=%0b we=%0b expected 0/0", rst_locked_after, rst_fbwe_after); end
    checks++; if (rst_mm_after !== 8'd0) begin errors++; $display("FAIL areset_mm: got %0d expected 0", rst_mm_after); end
    vs_pulse;
    checks++; if (locked_post !== 1'b0) begin errors++; $display("FAIL areset_vs1: got %0b expected 0", locked_post); end
    clear_mon;
    send_frame(VA, -1, 0, 1'b0, -1);
    checks++; if (wr_count !== 0) begin errors++; $display("FAIL areset_measure_writes: got %0d expected 0", wr_count); end
    vs_pulse;
    checks++; if (locked_pre !== 1'b0 || locked_post !== 1'b1) begin errors++; $display("FAIL areset_vs2: got pre=%0b post=%0b expected 0/1", locked_pre, locked_post); end
    clear_mon;
    send_frame(VA, -1, 0, 1'b0, -1);
    checks++; if (wr_count !== 32) begin errors++; $display("FAIL areset_capture: got %0d expected 32", wr_count); end
    vs_pulse;
    checks++; if (done_post !== 1'b1) begin errors++; $display("FAIL areset_done: got %0b expected 1", done_post); end
  endtask

  task automatic test_long_frame;
    clear_mon;
    send_frame(VA + 2, -1, 0, 1'b0, -1);
    checks++; if (wr_count !== 32 || last_addr !== 16'h0307) begin errors++; $display("FAIL long_frame_writes: got n=%0d last=%04h expected 32/0307", wr_count, last_addr); end
    vs_pulse;
    checks++; if (vmeas_post !== 12'd26 || locked_post !== 1'b0 || mm_post !== 8'd1) begin errors++; $display("FAIL long_frame_vs: got v=%0d locked=%0b mm=%0d expected 26/0/1", vmeas_post, locked_post, mm_post); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.de = 1'b0; vif.hsync = 1'b0; vif.vsync = 1'b0; vif.video = '0;
    pat_mode = 1'b0; rst_bad = 0;
    clear_mon;
    repeat (3) @(posedge clk);
    test_reset;
    test_lock_in;
    test_mapping;
    test_short_frame;
    test_short_line;
    test_async_reset;
    test_long_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
